regfile_wb_arbiter: RTL and testbench

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 76 +++++++
 tb/tb_regfile_wb_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester register-file writeback arbiter with hazard flags
module regfile_wb_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        RegWrite,
    output logic [4:0]  WriteRegister,
    output logic [31:0] WriteData,
    output logic        hazard1,
    output logic        hazard2,
    output logic [15:0] wr_cnt
);

    // 0 = A preferred on a tie, 1 = B preferred
    logic        prio;
    logic        grant;
    logic [4:0]  grantAddr;
    logic [31:0] grantData;

    // Grant selection: a lone requester always wins, a tie goes to the preferred side
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!reset && !hold) begin
            if (a_valid && (!b_valid || !prio)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    assign grant     = a_ready | b_ready;
    assign grantAddr = a_ready ? a_addr : b_addr;
    assign grantData = a_ready ? a_data : b_data;

    // Round-robin pointer: after a grant, favour the side that lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (grant) begin
            prio <= a_ready;
        end
    end

    // Write port register: writes to x0 are accepted but never committed or counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= 5'd0;
            WriteData     <= 32'd0;
            wr_cnt        <= 16'd0;
        end else if (grant && (grantAddr != 5'd0)) begin
            RegWrite      <= 1'b1;
            WriteRegister <= grantAddr;
            WriteData     <= grantData;
            wr_cnt        <= wr_cnt + 16'd1;
        end else begin
            RegWrite      <= 1'b0;
        end
    end

    assign hazard1 = RegWrite && (WriteRegister == rs1) && (rs1 != 5'd0);
    assign hazard2 = RegWrite && (WriteRegister == rs2) && (rs2 != 5'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        hold;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        hazard1;
    logic        hazard2;
    logic [15:0] wr_cnt;

    int nVec;
    int nMiss;

    regfile_wb_arbiter dut (
        .clk(clk),
        .reset(reset),
        .hold(hold),
        .a_valid(a_valid),
        .a_addr(a_addr),
        .a_data(a_data),
        .a_ready(a_ready),
        .b_valid(b_valid),
        .b_addr(b_addr),
        .b_data(b_data),
        .b_ready(b_ready),
        .rs1(rs1),
        .rs2(rs2),
        .RegWrite(RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData(WriteData),
        .hazard1(hazard1),
        .hazard2(hazard2),
        .wr_cnt(wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        aValid;
        logic [4:0]  aAddr;
        logic [31:0] aData;
        logic        bValid;
        logic [4:0]  bAddr;
        logic [31:0] bData;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        eARdy;
        logic        eBRdy;
        logic        eH1;
        logic        eH2;
        logic        eRW;
        logic [4:0]  eWR;
        logic [31:0] eWD;
        logic [15:0] eCnt;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVec++;
        if (actual !== expected) begin
            nMiss++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        nVec  = 0;
        nMiss = 0;

        //          hold  aV    aAddr  aData          bV    bAddr  bData        rs1    rs2    aR    bR    h1    h2    RW    WR     WD             cnt
        vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,       5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 16'd1};
        vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h1234,    5'd5,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5,  32'hDEADBEEF, 16'd1};
        vecs[2]  = '{1'b0, 1'b1, 5'd1,  32'h101,      1'b1, 5'd9,  32'h209,     5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1,  32'h101,      16'd2};
        vecs[3]  = '{1'b0, 1'b1, 5'd2,  32'h102,      1'b1, 5'd9,  32'h209,     5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9,  32'h209,      16'd3};
        vecs[4]  = '{1'b0, 1'b1, 5'd2,  32'h102,      1'b1, 5'd10, 32'h20A,     5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd2,  32'h102,      16'd4};
        vecs[5]  = '{1'b0, 1'b1, 5'd3,  32'h103,      1'b1, 5'd10, 32'h20A,     5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'h20A,      16'd5};
        vecs[6]  = '{1'b1, 1'b1, 5'd3,  32'h103,      1'b0, 5'd0,  32'h0,       5'd10, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 32'h20A,      16'd5};
        vecs[7]  = '{1'b1, 1'b1, 5'd3,  32'h103,      1'b0, 5'd0,  32'h0,       5'd10, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h20A,      16'd5};
        vecs[8]  = '{1'b1, 1'b1, 5'd3,  32'h103,      1'b0, 5'd0,  32'h0,       5'd10, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd10, 32'h20A,      16'd5};
        vecs[9]  = '{1'b0, 1'b1, 5'd3,  32'h103,      1'b0, 5'd0,  32'h0,       5'd10, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3,  32'h103,      16'd6};
        vecs[10] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd3,  5'd3,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd3,  32'h103,      16'd6};
        vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,       5'd3,  5'd3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3,  32'h103,      16'd6};
        vecs[12] = '{1'b0, 1'b1, 5'd4,  32'h104,      1'b1, 5'd11, 32'h20B,     5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h20B,      16'd7};
        vecs[13] = '{1'b0, 1'b1, 5'd4,  32'h104,      1'b1, 5'd12, 32'h20C,     5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4,  32'h104,      16'd8};
        vecs[14] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h20C,     5'd4,  5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd12, 32'h20C,      16'd9};

        reset   = 1'b1;
        hold    = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd3;
        a_data  = 32'h55;
        b_valid = 1'b1;
        b_addr  = 5'd4;
        b_data  = 32'h66;
        rs1     = 5'd0;
        rs2     = 5'd0;

        #3;
        check("reset RegWrite", {31'd0, RegWrite}, 32'd0);
        check("reset WriteRegister", {27'd0, WriteRegister}, 32'd0);
        check("reset WriteData", WriteData, 32'd0);
        check("reset wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check("reset a_ready", {31'd0, a_ready}, 32'd0);
        check("reset b_ready", {31'd0, b_ready}, 32'd0);

        @(negedge clk);
        reset   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            hold    = vecs[i].hold;
            a_valid = vecs[i].aValid;
            a_addr  = vecs[i].aAddr;
            a_data  = vecs[i].aData;
            b_valid = vecs[i].bValid;
            b_addr  = vecs[i].bAddr;
            b_data  = vecs[i].bData;
            rs1     = vecs[i].rs1;
            rs2     = vecs[i].rs2;
            #1;
            check($sformatf("v%0d a_ready", i), {31'd0, a_ready}, {31'd0, vecs[i].eARdy});
            check($sformatf("v%0d b_ready", i), {31'd0, b_ready}, {31'd0, vecs[i].eBRdy});
            check($sformatf("v%0d hazard1", i), {31'd0, hazard1}, {31'd0, vecs[i].eH1});
            check($sformatf("v%0d hazard2", i), {31'd0, hazard2}, {31'd0, vecs[i].eH2});
            @(posedge clk);
            #1;
            check($sformatf("v%0d RegWrite", i), {31'd0, RegWrite}, {31'd0, vecs[i].eRW});
            check($sformatf("v%0d WriteRegister", i), {27'd0, WriteRegister}, {27'd0, vecs[i].eWR});
            check($sformatf("v%0d WriteData", i), WriteData, vecs[i].eWD);
            check($sformatf("v%0d wr_cnt", i), {16'd0, wr_cnt}, {16'd0, vecs[i].eCnt});
        end

        // Hazard on a just-registered write, then reset discards it
        @(negedge clk);
        hold    = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd7;
        a_data  = 32'h77;
        b_valid = 1'b0;
        rs1     = 5'd0;
        rs2     = 5'd0;
        @(posedge clk);
        #1;
        check("s1 RegWrite", {31'd0, RegWrite}, 32'd1);
        check("s1 WriteRegister", {27'd0, WriteRegister}, 32'd7);
        @(negedge clk);
        a_valid = 1'b0;
        rs1     = 5'd7;
        rs2     = 5'd0;
        #1;
        check("s1 hazard1", {31'd0, hazard1}, 32'd1);
        check("s1 hazard2", {31'd0, hazard2}, 32'd0);
        reset = 1'b1;
        #1;
        check("s1 reset RegWrite", {31'd0, RegWrite}, 32'd0);
        check("s1 reset hazard1", {31'd0, hazard1}, 32'd0);
        check("s1 reset wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check("s1 reset WriteRegister", {27'd0, WriteRegister}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // First tie after reset goes to A even though the last grant was A
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = 5'd6;
        a_data  = 32'h66;
        b_valid = 1'b1;
        b_addr  = 5'd8;
        b_data  = 32'h88;
        rs1     = 5'd0;
        #1;
        check("s2 a_ready", {31'd0, a_ready}, 32'd1);
        check("s2 b_ready", {31'd0, b_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("s2 WriteRegister", {27'd0, WriteRegister}, 32'd6);
        check("s2 wr_cnt", {16'd0, wr_cnt}, 32'd1);

        // Counter wrap after 65535 back-to-back writes
        @(negedge clk);
        reset   = 1'b1;
        b_valid = 1'b0;
        a_valid = 1'b1;
        a_addr  = 5'd1;
        a_data  = 32'h1;
        #1;
        reset = 1'b0;
        repeat (65535) @(posedge clk);
        #1;
        check("wrap pre wr_cnt", {16'd0, wr_cnt}, 32'h0000FFFF);
        @(posedge clk);
        #1;
        check("wrap wr_cnt", {16'd0, wr_cnt}, 32'd0);
        check("wrap RegWrite", {31'd0, RegWrite}, 32'd1);
        a_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
